// File: rtl/quad_dec_sysinfo_if.sv
// Avalon-MM style control-bus bundle for the quad_dec system-information slave.
// The master drives address/strobes/data; the slave returns registered read data.
interface quad_dec_sysinfo_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/quad_dec_sysinfo.sv
// System-information slave: build identity words, capabilities, a free-running
// uptime counter with a coherent hi/lo snapshot, CTRL/status and scratch words.
// Reads return one cycle after the strobe; writes land at the end of the strobe cycle.
module quad_dec_sysinfo #(
  parameter logic [31:0] SYSTEM_ID     = 32'h5AF0_1C3B,
  parameter logic [31:0] TIMESTAMP     = 32'd0,
  parameter logic [15:0] VERSION       = 16'd2,
  parameter int          UPTIME_W      = 64,
  parameter int          SCRATCH_WORDS = 4,
  parameter int          ADDR_W        = 5
) (
  input logic             clock,
  input logic             reset_n,
  quad_dec_sysinfo_if.slave bus
);

  localparam logic [ADDR_W-1:0] A_ID   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TS   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CAPS = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_LO   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_HI   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(5);
  localparam int                A_SCR0 = 6;

  localparam logic [31:0] CAPS_WORD = {8'(SCRATCH_WORDS), 8'(UPTIME_W), VERSION};

  logic [UPTIME_W-1:0] counter;
  logic [63:0]         cnt_ext;
  logic [31:0]         hi_shadow;
  logic                en;
  logic                ovf;
  logic [31:0]         scratch [SCRATCH_WORDS];
  logic [31:0]         rd_mux;
  logic [31:0]         readdata_q;
  logic                rdvalid_q;

  logic ctrl_wr;
  logic clr;
  logic wrap;

  // CTRL is a single-byte register, so only lane 0 can reach it.
  assign ctrl_wr = bus.write && (bus.address == A_CTRL) && bus.byteenable[0];
  assign clr     = ctrl_wr && bus.writedata[1];
  assign wrap    = en && (&counter);
  assign cnt_ext = 64'(counter);

  // Uptime counter, enable and sticky overflow; a clear suppresses the overflow of the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter <= '0;
      en      <= 1'b1;
      ovf     <= 1'b0;
    end else begin
      if (clr) begin
        counter <= '0;
      end else if (en) begin
        counter <= counter + UPTIME_W'(1);
      end
      if (ctrl_wr) begin
        en <= bus.writedata[0];
      end
      if (wrap && !clr) begin
        ovf <= 1'b1;
      end else if (ctrl_wr && bus.writedata[2]) begin
        ovf <= 1'b0;
      end
    end
  end

  // Scratch words with per-byte write enables.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SCRATCH_WORDS; i++) begin
        scratch[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SCRATCH_WORDS; i++) begin
        if (bus.write && (bus.address == ADDR_W'(A_SCR0 + i))) begin
          for (int b = 0; b < 4; b++) begin
            if (bus.byteenable[b]) begin
              scratch[i][8*b +: 8] <= bus.writedata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Read-data selection from the pre-write register state.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      A_ID:    rd_mux = SYSTEM_ID;
      A_TS:    rd_mux = TIMESTAMP;
      A_CAPS:  rd_mux = CAPS_WORD;
      A_LO:    rd_mux = cnt_ext[31:0];
      A_HI:    rd_mux = hi_shadow;
      A_CTRL:  rd_mux = {29'd0, ovf, 1'b0, en};
      default: rd_mux = '0;
    endcase
    for (int i = 0; i < SCRATCH_WORDS; i++) begin
      if (bus.address == ADDR_W'(A_SCR0 + i)) begin
        rd_mux = scratch[i];
      end
    end
  end

  // Registered read response; a LO read also latches the matching upper bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      rdvalid_q  <= 1'b0;
      hi_shadow  <= '0;
    end else begin
      rdvalid_q <= bus.read;
      if (bus.read) begin
        readdata_q <= rd_mux;
      end
      if (bus.read && (bus.address == A_LO)) begin
        hi_shadow <= cnt_ext[63:32];
      end
    end
  end

  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = rdvalid_q;

endmodule

// File: tb/tb_quad_dec_sysinfo.sv
// Directed bench for quad_dec_sysinfo: a default 64-bit build and a 33-bit build
// with two scratch words. Expected read data is queued at issue time and checked
// by a monitor when readdatavalid appears.
module tb_quad_dec_sysinfo;

  localparam logic [31:0] SYS_ID = 32'h5AF0_1C3B;
  localparam logic [31:0] TS33   = 32'h6502_1A00;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;

  quad_dec_sysinfo_if #(.ADDR_W(5)) b0 ();
  quad_dec_sysinfo_if #(.ADDR_W(4)) b1 ();

  quad_dec_sysinfo dut64 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b0)
  );

  quad_dec_sysinfo #(
    .TIMESTAMP     (TS33),
    .UPTIME_W      (33),
    .SCRATCH_WORDS (2),
    .ADDR_W        (4)
  ) dut33 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic mon_one(input int sel, input logic v, input logic [31:0] d);
    exp_t e;
    int   qs;
    qs = (sel == 0) ? q0.size() : q1.size();
    if (!reset_n) begin
      if (sel == 0) last0 = '0; else last1 = '0;
      return;
    end
    if (v) begin
      if (qs == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dut%0d unexpected readdatavalid: got data %h expected no response", sel, d);
      end else begin
        if (sel == 0) e = q0.pop_front(); else e = q1.pop_front();
        check({e.tag, " data"}, d, e.data);
        check({e.tag, " latency"}, 32'(cyc), 32'(e.cyc + 1));
      end
      if (sel == 0) last0 = d; else last1 = d;
    end else begin
      check($sformatf("dut%0d readdata hold", sel), d, (sel == 0) ? last0 : last1);
      if (qs != 0) begin
        if (sel == 0) e = q0[0]; else e = q1[0];
        if (e.cyc < cyc - 1) begin
          n_vec++;
          n_err++;
          $display("FAIL %s timeout: got no readdatavalid expected data %h", e.tag, e.data);
          if (sel == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      mon_one(0, b0.readdatavalid, b0.readdata);
      mon_one(1, b1.readdatavalid, b1.readdata);
    end
  endtask

  task automatic clear_bus();
    b0.read = 1'b0; b0.write = 1'b0; b0.address = '0; b0.writedata = '0; b0.byteenable = '0;
    b1.read = 1'b0; b1.write = 1'b0; b1.address = '0; b1.writedata = '0; b1.byteenable = '0;
  endtask

  task automatic op(input int sel, input bit r, input bit w, input logic [4:0] a,
                    input logic [31:0] wd, input logic [3:0] be,
                    input logic [31:0] exp, input string tag);
    exp_t e;
    if (sel == 0) begin
      b0.read = r; b0.write = w; b0.address = a; b0.writedata = wd; b0.byteenable = be;
    end else begin
      b1.read = r; b1.write = w; b1.address = a[3:0]; b1.writedata = wd; b1.byteenable = be;
    end
    if (r) begin
      e.cyc = cyc; e.data = exp; e.tag = tag;
      if (sel == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(negedge clock);
    clear_bus();
  endtask

  task automatic rd(input int sel, input logic [4:0] a, input logic [31:0] exp, input string tag);
    op(sel, 1'b1, 1'b0, a, 32'd0, 4'h0, exp, tag);
  endtask

  task automatic wr(input int sel, input logic [4:0] a, input logic [31:0] wd, input logic [3:0] be);
    op(sel, 1'b0, 1'b1, a, wd, be, 32'd0, "");
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Preset the live counter for one idle cycle; it resumes counting from the value.
  task automatic force_cnt64(input logic [63:0] v);
    force dut64.counter = v;
    #1 release dut64.counter;
    @(negedge clock);
  endtask

  task automatic force_cnt33(input logic [32:0] v);
    force dut33.counter = v;
    #1 release dut33.counter;
    @(negedge clock);
  endtask

  initial begin
    clear_bus();
    #2 reset_n = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clock);
    check("reset dut64 valid", 32'(b0.readdatavalid), 32'd0);
    check("reset dut64 data", b0.readdata, 32'd0);
    check("reset dut33 valid", 32'(b1.readdatavalid), 32'd0);
    reset_n = 1'b1;

    // identity words back-to-back
    rd(0, 5'd0, SYS_ID, "dut64 ID");
    rd(0, 5'd1, 32'd0, "dut64 TS");
    rd(0, 5'd2, 32'h0440_0002, "dut64 CAPS");
    idle(2);
    rd(1, 5'd0, SYS_ID, "dut33 ID");
    rd(1, 5'd1, TS33, "dut33 TS");
    rd(1, 5'd2, 32'h0221_0002, "dut33 CAPS");
    rd(0, 5'd5, 32'h1, "dut64 CTRL reset");

    // coherent snapshot across a low-word carry
    force_cnt64(64'h0000_0007_FFFF_FFFD);
    rd(0, 5'd3, 32'hFFFF_FFFE, "snap LO");
    idle(5);
    rd(0, 5'd4, 32'h0000_0007, "snap HI");
    rd(0, 5'd3, 32'h0000_0005, "snap LO2");
    rd(0, 5'd4, 32'h0000_0008, "snap HI2");

    // scratch byte enables, out-of-map, read/write collision
    wr(0, 5'd7, 32'hA5A5_A5A5, 4'hF);
    wr(0, 5'd7, 32'h1234_5678, 4'h5);
    rd(0, 5'd7, 32'hA534_A578, "scratch1 byteen");
    wr(0, 5'd9, 32'hCAFE_F00D, 4'hF);
    rd(0, 5'd9, 32'hCAFE_F00D, "scratch3 last");
    wr(0, 5'd10, 32'hDEAD_BEEF, 4'hF);
    rd(0, 5'd10, 32'd0, "out of map 10");
    rd(0, 5'd31, 32'd0, "out of map 31");
    wr(0, 5'd6, 32'h1111_1111, 4'hF);
    op(0, 1'b1, 1'b1, 5'd6, 32'h2222_2222, 4'hF, 32'h1111_1111, "rw collision old");
    rd(0, 5'd6, 32'h2222_2222, "rw collision new");
    wr(1, 5'd8, 32'hFFFF_FFFF, 4'hF);
    rd(1, 5'd8, 32'd0, "dut33 out of map 8");
    wr(1, 5'd7, 32'h0BAD_CAFE, 4'hC);
    rd(1, 5'd7, 32'h0BAD_0000, "dut33 scratch1 hi lanes");

    // EN=0 freezes the counter
    force_cnt64(64'd100);
    wr(0, 5'd5, 32'h0, 4'h1);
    rd(0, 5'd3, 32'd102, "EN0 LO first");
    idle(10);
    rd(0, 5'd3, 32'd102, "EN0 LO second");
    rd(0, 5'd5, 32'h0, "CTRL EN0");
    wr(0, 5'd5, 32'h1, 4'hE);
    rd(0, 5'd5, 32'h0, "CTRL lane0 off");

    // CLR with EN=1 restarts from 0
    wr(0, 5'd5, 32'h3, 4'h1);
    idle(2);
    rd(0, 5'd3, 32'd2, "CLR LO elapsed");
    rd(0, 5'd5, 32'h1, "CTRL CLR reads 0");

    // 33-bit build: zero-extended upper word
    force_cnt33(33'h1_0000_0010);
    rd(1, 5'd3, 32'h0000_0011, "dut33 snap LO");
    rd(1, 5'd4, 32'h0000_0001, "dut33 snap HI");

    // wrap sets OVF and the counter restarts
    force_cnt33(33'h1_FFFF_FFFE);
    idle(1);
    rd(1, 5'd3, 32'd0, "wrap LO");
    rd(1, 5'd5, 32'h5, "wrap OVF set");
    rd(1, 5'd4, 32'd0, "wrap HI");
    wr(1, 5'd5, 32'h5, 4'h1);
    rd(1, 5'd5, 32'h1, "OVF W1C");

    // W1C in the wrap cycle loses to the set
    force_cnt33(33'h1_FFFF_FFFE);
    wr(1, 5'd5, 32'h5, 4'h1);
    rd(1, 5'd5, 32'h5, "W1C at wrap");
    wr(1, 5'd5, 32'h5, 4'h1);
    rd(1, 5'd5, 32'h1, "OVF cleared again");

    // CLR in the wrap cycle suppresses OVF
    force_cnt33(33'h1_FFFF_FFFE);
    wr(1, 5'd5, 32'h3, 4'h1);
    rd(1, 5'd3, 32'd0, "CLR at wrap LO");
    rd(1, 5'd5, 32'h1, "CLR at wrap OVF");

    // reset during an outstanding response
    wr(0, 5'd5, 32'h0, 4'h1);
    b0.read = 1'b1;
    b0.address = 5'd1;
    @(posedge clock);
    #1;
    check("mid-read valid before reset", 32'(b0.readdatavalid), 32'd1);
    reset_n = 1'b0;
    clear_bus();
    #1;
    check("mid-read valid after reset", 32'(b0.readdatavalid), 32'd0);
    check("mid-read data after reset", b0.readdata, 32'd0);
    q0.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    rd(0, 5'd5, 32'h1, "post-reset CTRL");
    rd(0, 5'd3, 32'd1, "post-reset LO");
    rd(0, 5'd4, 32'd0, "post-reset HI");
    rd(0, 5'd7, 32'd0, "post-reset scratch1");
    rd(0, 5'd6, 32'd0, "post-reset scratch0");
    rd(1, 5'd5, 32'h1, "post-reset dut33 CTRL");
    rd(1, 5'd7, 32'd0, "post-reset dut33 scratch1");

    idle(3);
    check("dut64 responses drained", 32'(q0.size()), 32'd0);
    check("dut33 responses drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/quad_dec_sysinfo.md
# quad_dec_sysinfo

Parametrised system-information slave for the Quad_Dec Qsys system, the next generation of the fixed system-ID ROM. It exposes build identity words, a capabilities word, a free-running uptime counter with coherent 64-bit snapshot reads, a control/status register and a bank of software scratch registers. It sits on the Avalon-MM control bus beside the other peripherals. Reads are registered with a fixed one-cycle latency.

## Interface
Parameters:
- SYSTEM_ID, 32'h5AF0_1C3B, value returned at word 0.
- TIMESTAMP, 32'd0, build timestamp returned at word 1.
- VERSION, 16'd2, block version in the CAPS word [15:0].
- UPTIME_W, 64, uptime counter width; legal range 33..64.
- SCRATCH_WORDS, 4, number of 32-bit scratch registers; legal range 1..16.
- ADDR_W, 5, word-address width; must cover 6+SCRATCH_WORDS words.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- address  in  ADDR_W  word address.
- read  in  1  read strobe, one cycle per access.
- write  in  1  write strobe, one cycle per access.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high for exactly one cycle, one cycle after an accepted read.

## Operation
Register map (word address):
- 0 ID: SYSTEM_ID, read-only.
- 1 TS: TIMESTAMP, read-only.
- 2 CAPS: {SCRATCH_WORDS[7:0], UPTIME_W[7:0], VERSION}, read-only.
- 3 UPTIME_LO: counter[31:0]. The same read loads hi_shadow with counter[UPTIME_W-1:32], zero-extended to 32 bits.
- 4 UPTIME_HI: returns hi_shadow. The live counter is not sampled.
- 5 CTRL: bit0 EN is R/W, reset 1. bit1 CLR is write-1 and reads 0. bit2 OVF is sticky and write-1-to-clear. Bits [31:3] read 0.
- 6..6+SCRATCH_WORDS-1 SCRATCH[n]: R/W. Each byte is written only when its byteenable bit is set.
- Any other address reads 0 and ignores writes.

Counter rules:
- When EN=1 the counter increments by 1 every clock, modulo 2^UPTIME_W.
- The wrap from all-ones to 0 sets OVF.
- When EN=0 the counter holds.
- Writing CLR=1 zeroes the counter on the next edge, regardless of EN. The EN bit of the same write still takes effect.
- byteenable applies to CTRL only through lane 0. With byteenable[0]=0, a CTRL write has no effect.

No waitrequest; every access is accepted in the cycle its strobe is high.

## Timing
- Reset (asynchronous assert, synchronous release):
  - readdata=0, readdatavalid=0.
  - counter=0, hi_shadow=0, EN=1, OVF=0.
  - All scratch registers are 0.
- Read latency is 1. A read in cycle N gives readdatavalid=1 and readdata valid in cycle N+1. Otherwise readdatavalid=0 and readdata holds its last value.
- Back-to-back reads each return in the following cycle; throughput is one read per clock.
- A UPTIME_LO read in cycle N returns the counter value present in cycle N. hi_shadow is written at the edge ending cycle N. A following UPTIME_HI read, in any later cycle, returns the matching upper bits.
- Writes take effect at the edge ending the strobe cycle.
- Read and write to the same address in one cycle: readdata returns the pre-write value.
- Simultaneous events on the counter and OVF:
  - CLR write in the same cycle as a wrap: CLR wins, and OVF is not set by that wrap.
  - OVF write-1-to-clear in the same cycle as a wrap: the set wins, so OVF=1.
- Reset asserted mid-read: readdatavalid drops to 0 immediately and no response is delivered.

## Test plan
- Reset, then read words 0, 1, 2 back-to-back → readdatavalid on 3 consecutive cycles, each one cycle after its read. Data is SYSTEM_ID, TIMESTAMP and 32'h0440_0002 (defaults).
- Coherent snapshot:
  - Force the counter to 32'hFFFF_FFFE in the lower word by waiting or with a UPTIME_W=33 build.
  - Read LO, idle 5 cycles, read HI.
  - → LO and HI form the value sampled at the LO read cycle. HI is unaffected by the carry that occurs during the idle cycles.
- Scratch byte enables: write 32'hA5A5_A5A5 with byteenable 4'hF to SCRATCH[1], then 32'h1234_5678 with byteenable 4'h5 → read returns 32'hA534_A578. An out-of-map address write followed by a read → 0.
- CTRL behaviour:
  - Write EN=0 → two UPTIME_LO reads 10 cycles apart are equal.
  - Write CLR=1 with EN=1 → the next LO read is small: equal to the elapsed cycles since the write.
  - CTRL bit1 reads 0.
- Overflow, UPTIME_W=33:
  - Run to the wrap → OVF=1 and the counter restarts at 0.
  - Write 4 (W1C) in the wrap cycle → OVF stays 1.
  - Write CLR in the wrap cycle → OVF stays 0.
- Assert reset_n low during an outstanding read → readdatavalid=0 asynchronously. After release, all registers are at reset values and EN=1.
